// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 slave terminating one interconnect port with a word-addressed SRAM,
// serving one single or burst transaction at a time.
module axi_sram_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH = 4,
  parameter int DEPTH = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h0010_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   aw_id,
  input  logic [ADDR_WIDTH-1:0] aw_addr,
  input  logic [7:0]            aw_len,
  input  logic [2:0]            aw_size,
  input  logic [1:0]            aw_burst,
  input  logic                  aw_valid,
  output logic                  aw_ready,
  input  logic [31:0]           w_data,
  input  logic [3:0]            w_strb,
  input  logic                  w_last,
  input  logic                  w_valid,
  output logic                  w_ready,
  output logic [ID_WIDTH-1:0]   b_id,
  output logic [1:0]            b_resp,
  output logic                  b_valid,
  input  logic                  b_ready,
  input  logic [ID_WIDTH-1:0]   ar_id,
  input  logic [ADDR_WIDTH-1:0] ar_addr,
  input  logic [7:0]            ar_len,
  input  logic [2:0]            ar_size,
  input  logic [1:0]            ar_burst,
  input  logic                  ar_valid,
  output logic                  ar_ready,
  output logic [ID_WIDTH-1:0]   r_id,
  output logic [31:0]           r_data,
  output logic [1:0]            r_resp,
  output logic                  r_last,
  output logic                  r_valid,
  input  logic                  r_ready
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, WDATA = 2'd1, WRESP = 2'd2, RDATA = 2'd3;
  localparam logic [ADDR_WIDTH:0] HI = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(4 * DEPTH);
  logic [1:0] state;
  logic last_rd;
  logic [ID_WIDTH-1:0] id;
  logic [ADDR_WIDTH-1:0] addr, nxt;
  logic [7:0] len, cnt;
  logic [2:0] size;
  logic [1:0] burst;
  logic err, do_w, do_r, w_hs, r_hs, w_bad, w_end, ar_bad, nxt_bad;
  logic [31:0] mem [DEPTH];
  function automatic logic bad(input logic [ADDR_WIDTH-1:0] a, input logic [2:0] s, input logic [1:0] b);
    return s != 3'd2 || b[1] || a < BASE_ADDR || {1'b0, a} >= HI;
  endfunction
  function automatic logic [IW-1:0] idx(input logic [ADDR_WIDTH-1:0] a);
    return IW'((a - BASE_ADDR) >> 2);
  endfunction
  // Round-robin on a same-cycle AW/AR collision: the side not served last wins.
  always_comb begin
    do_w = state == IDLE && aw_ready && aw_valid && (!ar_valid || last_rd);
    do_r = state == IDLE && ar_ready && ar_valid && !do_w;
    w_hs = state == WDATA && w_valid && w_ready;
    r_hs = state == RDATA && r_valid && r_ready;
    w_bad = bad(addr, size, burst);
    w_end = cnt == len;
    ar_bad = bad(ar_addr, ar_size, ar_burst);
    nxt = burst == 2'b00 ? addr : addr + ADDR_WIDTH'(4);
    nxt_bad = bad(nxt, size, burst);
  end
  always_ff @(posedge clk)
    if (w_hs && !w_bad)
      for (int i = 0; i < 4; i++)
        if (w_strb[i]) mem[idx(addr)][8*i +: 8] <= w_data[8*i +: 8];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last_rd <= 1'b1;
      aw_ready <= 1'b0;
      ar_ready <= 1'b0;
      w_ready <= 1'b0;
      b_valid <= 1'b0;
      b_id <= '0;
      b_resp <= 2'b00;
      r_valid <= 1'b0;
      r_id <= '0;
      r_data <= '0;
      r_resp <= 2'b00;
      r_last <= 1'b0;
      id <= '0;
      addr <= '0;
      len <= '0;
      cnt <= '0;
      size <= '0;
      burst <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          aw_ready <= !(do_w || do_r);
          ar_ready <= !(do_w || do_r);
          if (do_w) begin
            state <= WDATA;
            last_rd <= 1'b0;
            w_ready <= 1'b1;
            id <= aw_id;
            addr <= aw_addr;
            len <= aw_len;
            size <= aw_size;
            burst <= aw_burst;
            cnt <= '0;
            err <= 1'b0;
          end else if (do_r) begin
            state <= RDATA;
            last_rd <= 1'b1;
            r_valid <= 1'b1;
            r_id <= ar_id;
            r_data <= ar_bad ? 32'd0 : mem[idx(ar_addr)];
            r_resp <= ar_bad ? 2'b10 : 2'b00;
            r_last <= ar_len == 8'd0;
            addr <= ar_addr;
            len <= ar_len;
            size <= ar_size;
            burst <= ar_burst;
            cnt <= '0;
          end
        end
        WDATA: if (w_hs) begin
          addr <= nxt;
          cnt <= cnt + 8'd1;
          err <= err || w_bad || w_last != w_end;
          if (w_end) begin
            state <= WRESP;
            w_ready <= 1'b0;
            b_valid <= 1'b1;
            b_id <= id;
            b_resp <= (err || w_bad || !w_last) ? 2'b10 : 2'b00;
          end
        end
        WRESP: if (b_ready) begin
          state <= IDLE;
          b_valid <= 1'b0;
          aw_ready <= 1'b1;
          ar_ready <= 1'b1;
        end
        default: if (r_hs) begin
          if (r_last) begin
            state <= IDLE;
            r_valid <= 1'b0;
            aw_ready <= 1'b1;
            ar_ready <= 1'b1;
          end else begin
            addr <= nxt;
            cnt <= cnt + 8'd1;
            r_data <= nxt_bad ? 32'd0 : mem[idx(nxt)];
            r_resp <= nxt_bad ? 2'b10 : 2'b00;
            r_last <= cnt + 8'd1 == len;
          end
        end
      endcase
    end
  end
endmodule
